smallseg_g0_update_ctrl: RTL and testbench

Update-side controller for the small-segment/G0 linked-list rule tables. It accepts insert and delete commands from the update path, walks a bucket's chain through the table's full-entry read port, and issues the table writes that append or unlink a rule entry. It owns the table's shared index/write port while busy; the search pipeline uses the port otherwise.

---
 rtl/smallseg_g0_update_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_smallseg_g0_update_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smallseg_g0_update_ctrl.sv
// Update-side controller for the small-segment/G0 linked-list rule tables.
// Walks a bucket chain through the table read port and appends or unlinks rule entries.
module smallseg_g0_update_ctrl #(
  parameter int unsigned TABLE_ENTRY_SIZE = 1738,
  parameter int unsigned INDEX_BIT_LEN    = 11,
  parameter int unsigned COMMAND_BIT_LEN  = 2,
  parameter int unsigned ENTRY_DATA_WIDTH = 171,
  parameter int unsigned FIRST_FREE       = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic [COMMAND_BIT_LEN-1:0]                cmd,
  input  logic [INDEX_BIT_LEN-1:0]                  cmd_head,
  input  logic [ENTRY_DATA_WIDTH-INDEX_BIT_LEN-1:0] cmd_rule,
  output logic                                      tbl_req,
  output logic [INDEX_BIT_LEN-1:0]                  tbl_index,
  output logic                                      tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0]               tbl_din,
  input  logic [ENTRY_DATA_WIDTH-1:0]               tbl_rd_data,
  output logic                                      done,
  output logic [2:0]                                status,
  output logic [INDEX_BIT_LEN-1:0]                  alloc_ptr
);

  localparam int unsigned RuleW = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
  localparam int unsigned HopW  = $clog2(TABLE_ENTRY_SIZE + 2);

  localparam logic [INDEX_BIT_LEN-1:0]   NULL_INDEX = '1;
  localparam logic [INDEX_BIT_LEN-1:0]   MaxIndex   = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
  localparam logic [INDEX_BIT_LEN-1:0]   FirstFree  = INDEX_BIT_LEN'(FIRST_FREE);
  localparam logic [HopW-1:0]            HopLimit   = HopW'(TABLE_ENTRY_SIZE + 1);
  localparam logic [COMMAND_BIT_LEN-1:0] CmdInsert  = COMMAND_BIT_LEN'(1);
  localparam logic [COMMAND_BIT_LEN-1:0] CmdDelete  = COMMAND_BIT_LEN'(2);

  localparam logic [2:0] StatOk       = 3'd0;
  localparam logic [2:0] StatFull     = 3'd1;
  localparam logic [2:0] StatNotFound = 3'd2;
  localparam logic [2:0] StatHead     = 3'd3;
  localparam logic [2:0] StatLoop     = 3'd4;
  localparam logic [2:0] StatBadCmd   = 3'd5;

  typedef enum logic [2:0] {
    StIdle, StRead, StCheck, StWrNew, StWrLink, StWrClr, StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [COMMAND_BIT_LEN-1:0]   cmd_q, cmd_d;
  logic [INDEX_BIT_LEN-1:0]     head_q, head_d;
  logic [RuleW-1:0]             rule_q, rule_d;
  logic [INDEX_BIT_LEN-1:0]     cur_q, cur_d;
  logic [INDEX_BIT_LEN-1:0]     prev_q, prev_d;
  logic [RuleW-1:0]             prev_data_q, prev_data_d;
  logic [INDEX_BIT_LEN-1:0]     link_idx_q, link_idx_d;
  logic [INDEX_BIT_LEN-1:0]     link_next_q, link_next_d;
  logic [RuleW-1:0]             link_data_q, link_data_d;
  logic [HopW-1:0]              hop_q, hop_d;
  logic [2:0]                   status_q, status_d;
  logic [INDEX_BIT_LEN-1:0]     alloc_q, alloc_d;

  logic [INDEX_BIT_LEN-1:0] rd_next;
  logic [INDEX_BIT_LEN-1:0] rd_id;
  logic [RuleW-1:0]         rd_rule;
  logic [INDEX_BIT_LEN-1:0] target_id;
  logic [HopW-1:0]          hop_inc;

  assign rd_next   = tbl_rd_data[ENTRY_DATA_WIDTH-1 -: INDEX_BIT_LEN];
  assign rd_rule   = tbl_rd_data[RuleW-1:0];
  assign rd_id     = tbl_rd_data[RuleW-1 -: INDEX_BIT_LEN];
  assign target_id = rule_q[RuleW-1 -: INDEX_BIT_LEN];
  assign hop_inc   = hop_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    head_d      = head_q;
    rule_d      = rule_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    prev_data_d = prev_data_q;
    link_idx_d  = link_idx_q;
    link_next_d = link_next_q;
    link_data_d = link_data_q;
    hop_d       = hop_q;
    status_d    = status_q;
    alloc_d     = alloc_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          head_d = cmd_head;
          rule_d = cmd_rule;
          cur_d  = cmd_head;
          prev_d = '0;
          hop_d  = '0;
          if (cmd != CmdInsert && cmd != CmdDelete) begin
            status_d = StatBadCmd;
            state_d  = StDone;
          end else if (cmd == CmdInsert && alloc_q > MaxIndex) begin
            status_d = StatFull;
            state_d  = StDone;
          end else begin
            state_d = StRead;
          end
        end
      end

      StRead: state_d = StCheck;

      StCheck: begin
        hop_d = hop_inc;
        if (cmd_q == CmdInsert) begin
          if (rd_next == NULL_INDEX) begin
            // Tail found: remember its word so WR_LINK can repoint it at the new slot.
            link_idx_d  = cur_q;
            link_next_d = alloc_q;
            link_data_d = rd_rule;
            state_d     = StWrNew;
          end else if (hop_inc == HopLimit) begin
            status_d = StatLoop;
            state_d  = StDone;
          end else begin
            prev_d      = cur_q;
            prev_data_d = rd_rule;
            cur_d       = rd_next;
            state_d     = StRead;
          end
        end else begin
          if (rd_id == target_id) begin
            if (cur_q == head_q) begin
              status_d = StatHead;
              state_d  = StDone;
            end else begin
              // Predecessor takes over the victim's next pointer.
              link_idx_d  = prev_q;
              link_next_d = rd_next;
              link_data_d = prev_data_q;
              state_d     = StWrLink;
            end
          end else if (rd_next == NULL_INDEX) begin
            status_d = StatNotFound;
            state_d  = StDone;
          end else if (hop_inc == HopLimit) begin
            status_d = StatLoop;
            state_d  = StDone;
          end else begin
            prev_d      = cur_q;
            prev_data_d = rd_rule;
            cur_d       = rd_next;
            state_d     = StRead;
          end
        end
      end

      StWrNew: state_d = StWrLink;

      StWrLink: begin
        if (cmd_q == CmdInsert) begin
          alloc_d  = alloc_q + 1'b1;
          status_d = StatOk;
          state_d  = StDone;
        end else begin
          state_d = StWrClr;
        end
      end

      StWrClr: begin
        status_d = StatOk;
        state_d  = StDone;
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      head_q      <= '0;
      rule_q      <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      prev_data_q <= '0;
      link_idx_q  <= '0;
      link_next_q <= '0;
      link_data_q <= '0;
      hop_q       <= '0;
      status_q    <= StatOk;
      alloc_q     <= FirstFree;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      head_q      <= head_d;
      rule_q      <= rule_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      prev_data_q <= prev_data_d;
      link_idx_q  <= link_idx_d;
      link_next_q <= link_next_d;
      link_data_q <= link_data_d;
      hop_q       <= hop_d;
      status_q    <= status_d;
      alloc_q     <= alloc_d;
    end
  end

  // Port drive decodes from registered state only; rst masks it so a reset wins over a write.
  always_comb begin
    tbl_index = '0;
    tbl_we    = 1'b0;
    tbl_din   = '0;
    if (!rst) begin
      unique case (state_q)
        StRead, StCheck: tbl_index = cur_q;
        StWrNew: begin
          tbl_index = alloc_q;
          tbl_we    = 1'b1;
          tbl_din   = {NULL_INDEX, rule_q};
        end
        StWrLink: begin
          tbl_index = link_idx_q;
          tbl_we    = 1'b1;
          tbl_din   = {link_next_q, link_data_q};
        end
        StWrClr: begin
          tbl_index = cur_q;
          tbl_we    = 1'b1;
          tbl_din   = {NULL_INDEX, {RuleW{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign tbl_req   = (state_q != StIdle) && !rst;
  assign done      = (state_q == StDone) && !rst;
  assign status    = status_q;
  assign alloc_ptr = alloc_q;

endmodule

// File: tb/tb_smallseg_g0_update_ctrl.sv
// Bench for smallseg_g0_update_ctrl: table vectors plus hand sequences, with a write/done
// scoreboard fed by a reference chain model over a shadow table.
module tb_smallseg_g0_update_ctrl;

  localparam logic [10:0] NullIdx = 11'h7ff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic [10:0]  cmd_head = '0;
  logic [159:0] cmd_rule = '0;
  logic         cmd_ready, tbl_req, tbl_we, done;
  logic [10:0]  tbl_index, alloc_ptr;
  logic [170:0] tbl_din, tbl_rd_data;
  logic [2:0]   status;

  always #5 clk = ~clk;

  smallseg_g0_update_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .cmd_head   (cmd_head),
    .cmd_rule   (cmd_rule),
    .tbl_req    (tbl_req),
    .tbl_index  (tbl_index),
    .tbl_we     (tbl_we),
    .tbl_din    (tbl_din),
    .tbl_rd_data(tbl_rd_data),
    .done       (done),
    .status     (status),
    .alloc_ptr  (alloc_ptr)
  );

  // Table with registered read; backdoor port for setup.
  logic [170:0] mem [0:2047];
  logic         bd_init = 1'b1;
  logic         bd_we = 1'b0;
  logic [10:0]  bd_idx = '0;
  logic [170:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= {NullIdx, 160'b0};
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (tbl_we) begin
      mem[tbl_index] <= tbl_din;
    end
    tbl_rd_data <= mem[tbl_index];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [10:0] idx; logic [170:0] data; int cyc; } wr_t;
  typedef struct { logic [2:0] status; int cyc; } dn_t;
  typedef struct {
    logic [1:0] c; logic [10:0] head; logic [10:0] id; logic [2:0] st; int dc; int alloc;
  } vec_t;

  wr_t          wr_q[$];
  dn_t          dn_q[$];
  logic [170:0] ref_mem [0:2047];
  int           ref_alloc = 1024;
  int           acc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  vec_t         vecs[12];

  task automatic chk(input string name, input logic [170:0] act, input logic [170:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] mk_rule(input logic [10:0] id);
    logic [159:0] pat;
    pat = {5{32'h9E3779B1 ^ {21'b0, id}}};
    return {id, 1'b1, pat[147:0]};
  endfunction

  function automatic void push_wr(input int idx, input logic [170:0] d, input int c);
    wr_t w;
    w.idx = 11'(idx); w.data = d; w.cyc = c;
    wr_q.push_back(w);
  endfunction

  // Reference chain walk: predicts table writes and their cycles, updates the shadow table.
  task automatic model(input logic [1:0] c, input logic [10:0] head, input logic [159:0] rule);
    logic [10:0]  cur, prev;
    logic [170:0] d, pd;
    cur = head; prev = '0; pd = '0;
    if (c == 2'b01) begin
      if (ref_alloc > 1738) return;
      for (int hop = 1; hop <= 1739; hop++) begin
        d = ref_mem[cur];
        if (d[170:160] == NullIdx) begin
          push_wr(ref_alloc, {NullIdx, rule}, 2 * hop);
          push_wr(int'(cur), {11'(ref_alloc), d[159:0]}, 2 * hop + 1);
          ref_mem[ref_alloc] = {NullIdx, rule};
          ref_mem[cur] = {11'(ref_alloc), d[159:0]};
          ref_alloc++;
          return;
        end
        cur = d[170:160];
      end
    end else if (c == 2'b10) begin
      for (int hop = 1; hop <= 1739; hop++) begin
        d = ref_mem[cur];
        if (d[159:149] == rule[159:149]) begin
          if (cur == head) return;
          push_wr(int'(prev), {d[170:160], pd[159:0]}, 2 * hop);
          push_wr(int'(cur), {NullIdx, 160'b0}, 2 * hop + 1);
          ref_mem[prev] = {d[170:160], pd[159:0]};
          ref_mem[cur] = {NullIdx, 160'b0};
          return;
        end
        if (d[170:160] == NullIdx) return;
        prev = cur; pd = d; cur = d[170:160];
      end
    end
  endtask

  task automatic bd_write(input logic [10:0] idx, input logic [170:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Returns #1 after the accepting edge, i.e. early in cycle 0.
  task automatic issue(input logic [1:0] c, input logic [10:0] head, input logic [159:0] r);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_head = head; cmd_rule = r;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chk("busy_cmd_ready", 171'(cmd_ready), 171'(0));
    chk("busy_tbl_req", 171'(tbl_req), 171'(1));
  endtask

  task automatic run_cmd(input vec_t v);
    logic [159:0] r;
    dn_t d;
    int n;
    r = mk_rule(v.id);
    model(v.c, v.head, r);
    d.status = v.st; d.cyc = v.dc;
    dn_q.push_back(d);
    issue(v.c, v.head, r);
    n = 0;
    while (dn_q.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    if (dn_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no done after %0d cycles (cmd %0d head %0d)", n, v.c, v.head);
      dn_q.delete();
    end
    chk("writes_outstanding", 171'(wr_q.size()), 171'(0));
    wr_q.delete();
    chk("alloc_ptr", 171'(alloc_ptr), 171'(v.alloc));
  endtask

  task automatic check_reset(input logic [2:0] st, input int al);
    chk("rst_cmd_ready", 171'(cmd_ready), 171'(0));
    chk("rst_tbl_req", 171'(tbl_req), 171'(0));
    chk("rst_tbl_we", 171'(tbl_we), 171'(0));
    chk("rst_tbl_index", 171'(tbl_index), 171'(0));
    chk("rst_tbl_din", tbl_din, 171'(0));
    chk("rst_done", 171'(done), 171'(0));
    chk("rst_status", 171'(status), 171'(st));
    chk("rst_alloc_ptr", 171'(alloc_ptr), 171'(al));
  endtask

  task automatic monitor_loop();
    wr_t w;
    dn_t d;
    int  rel;
    forever begin
      @(negedge clk);
      rel = cyc - acc;
      if (!rst && tbl_we) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: idx %0d data %0h at cycle %0d, none expected",
                   tbl_index, tbl_din, rel);
        end else begin
          w = wr_q.pop_front();
          chk("wr_index", 171'(tbl_index), 171'(w.idx));
          chk("wr_data", tbl_din, w.data);
          chk("wr_cycle", 171'(rel), 171'(w.cyc));
        end
      end
      if (!rst && done) begin
        if (dn_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: status %0d at cycle %0d", status, rel);
        end else begin
          d = dn_q.pop_front();
          chk("done_status", 171'(status), 171'(d.status));
          chk("done_cycle", 171'(rel), 171'(d.cyc));
        end
      end
    end
  endtask

  task automatic main_seq();
    vec_t         v;
    logic [159:0] r;
    int           n;
    // {cmd, head, ruleID, status, done cycle, alloc_ptr after}
    vecs[0]  = '{2'b01, 11'd3, 11'd5,  3'd0, 4,    1025}; // append to single-entry chain
    vecs[1]  = '{2'b01, 11'd3, 11'd6,  3'd0, 6,    1026}; // 3->1024->1025
    vecs[2]  = '{2'b10, 11'd3, 11'd5,  3'd0, 6,    1026}; // unlink middle entry 1024
    vecs[3]  = '{2'b10, 11'd3, 11'd9,  3'd2, 4,    1026}; // absent ruleID
    vecs[4]  = '{2'b10, 11'd3, 11'd3,  3'd3, 2,    1026}; // head ruleID
    vecs[5]  = '{2'b11, 11'd3, 11'd5,  3'd5, 0,    1026}; // illegal 11
    vecs[6]  = '{2'b01, 11'd3, 11'd7,  3'd0, 6,    1027}; // 3->1025->1026
    vecs[7]  = '{2'b10, 11'd3, 11'd7,  3'd0, 8,    1027}; // unlink third entry
    vecs[8]  = '{2'b01, 11'd7, 11'd8,  3'd4, 3478, 1027}; // self-loop insert
    vecs[9]  = '{2'b10, 11'd7, 11'd99, 3'd4, 3478, 1027}; // self-loop delete
    vecs[10] = '{2'b10, 11'd3, 11'd6,  3'd0, 6,    1027}; // unlink second entry 1025
    vecs[11] = '{2'b00, 11'd3, 11'd5,  3'd5, 0,    1027}; // illegal 00

    for (int i = 0; i < 2048; i++) ref_mem[i] = {NullIdx, 160'b0};
    @(negedge clk);
    @(negedge clk);
    bd_init = 1'b0;
    bd_write(11'd3, {NullIdx, mk_rule(11'd3)});
    bd_write(11'd7, {11'd7, mk_rule(11'd77)});

    check_reset(3'd0, 1024);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 171'(cmd_ready), 171'(1));

    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // Reset lands on WR_LINK: only WR_NEW reaches the table, the tail link is lost.
    r = mk_rule(11'd40);
    push_wr(ref_alloc, {NullIdx, r}, 2);
    ref_mem[ref_alloc] = {NullIdx, r};
    issue(2'b01, 11'd20, r);
    n = 0;
    while (cyc - acc < 3 && n < 10) begin @(posedge clk); #1; n++; end
    chk("wrlink_we_before_rst", 171'(tbl_we), 171'(1));
    rst = 1'b1;
    #1;
    chk("rst_cycle_tbl_we", 171'(tbl_we), 171'(0));
    chk("rst_cycle_tbl_req", 171'(tbl_req), 171'(0));
    chk("rst_cycle_tbl_index", 171'(tbl_index), 171'(0));
    chk("rst_cycle_tbl_din", tbl_din, 171'(0));
    chk("rst_cycle_cmd_ready", 171'(cmd_ready), 171'(0));
    @(posedge clk);
    #1;
    check_reset(3'd0, 1024);
    chk("wr_new_consumed", 171'(wr_q.size()), 171'(0));
    wr_q.delete();
    chk("tail_unlinked", mem[20], ref_mem[20]);
    ref_alloc = 1024;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 171'(cmd_ready), 171'(1));

    // Fill the allocator up to the last valid slot, then one more insert must report FULL.
    for (int i = 0; i < 714; i++) begin
      v = '{2'b01, 11'(100 + i), 11'(200 + i), 3'd0, 4, 1025 + i};
      run_cmd(v);
    end
    v = '{2'b01, 11'd900, 11'd50, 3'd0, 4, 1739};
    run_cmd(v);
    v = '{2'b01, 11'd901, 11'd51, 3'd1, 0, 1739};
    run_cmd(v);
  endtask

  initial begin
    fork
      monitor_loop();
      main_seq();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
